// File: rtl/control_sequencer.sv
// Hardwired control unit for alu_system. It fetches a 16-bit instruction as two
// bytes, then issues opcode-specific execute words stepped by a 2-bit counter.
module control_sequencer #(
    parameter logic [3:0] ALU_PASS = 4'b0000,
    parameter logic [3:0] ALU_ADD  = 4'b0100,
    parameter logic [3:0] ALU_SUB  = 4'b0101,
    parameter logic [3:0] ALU_AND  = 4'b0111
) (
    input  logic        Clock,
    input  logic        Reset,
    input  logic [15:0] IROut,
    input  logic [3:0]  ALUOutFlag,
    output logic [1:0]  RF_OutASel,
    output logic [1:0]  RF_OutBSel,
    output logic [1:0]  RF_FunSel,
    output logic [3:0]  RF_RegSel,
    output logic [3:0]  ALU_FunSel,
    output logic [1:0]  ARF_OutCSel,
    output logic [1:0]  ARF_OutDSel,
    output logic [1:0]  ARF_FunSel,
    output logic [2:0]  ARF_RegSel,
    output logic        IR_LH,
    output logic        IR_Enable,
    output logic [1:0]  IR_Funsel,
    output logic        Mem_WR,
    output logic        Mem_CS,
    output logic [1:0]  MuxASel,
    output logic [1:0]  MuxBSel,
    output logic        MuxCSel,
    output logic [1:0]  SC
);

    typedef enum logic [1:0] {
        T0 = 2'd0,
        T1 = 2'd1,
        T2 = 2'd2,
        T3 = 2'd3
    } step_e;

    localparam logic [3:0] OP_LDI  = 4'h0;
    localparam logic [3:0] OP_LDM  = 4'h1;
    localparam logic [3:0] OP_ST   = 4'h2;
    localparam logic [3:0] OP_LDAR = 4'h3;
    localparam logic [3:0] OP_ADD  = 4'h4;
    localparam logic [3:0] OP_SUB  = 4'h5;
    localparam logic [3:0] OP_AND  = 4'h6;
    localparam logic [3:0] OP_INC  = 4'h7;
    localparam logic [3:0] OP_BRA  = 4'h8;
    localparam logic [3:0] OP_BEQ  = 4'h9;

    localparam logic [1:0] FUN_CLEAR = 2'b00;
    localparam logic [1:0] FUN_LOAD  = 2'b01;
    localparam logic [1:0] FUN_INC   = 2'b11;

    localparam logic [1:0] MUX_ALU = 2'b00;
    localparam logic [1:0] MUX_MEM = 2'b01;
    localparam logic [1:0] MUX_IMM = 2'b10;

    localparam logic [2:0] ARF_SEL_PC  = 3'b100;
    localparam logic [2:0] ARF_SEL_AR  = 3'b010;
    localparam logic [2:0] ARF_SEL_ALL = 3'b111;

    localparam logic [1:0] OUTD_PC = 2'b00;
    localparam logic [1:0] OUTD_AR = 2'b01;

    step_e      sc_q;
    step_e      sc_d;
    logic [3:0] opcode;
    logic [1:0] rd;
    logic [1:0] rs1;
    logic [1:0] rs2;
    logic       alu_op;
    logic [3:0] alu_code;
    logic       unused_inputs;

    assign opcode = IROut[15:12];
    assign rd     = IROut[11:10];
    assign rs1    = IROut[9:8];
    assign rs2    = IROut[7:6];
    assign alu_op = opcode inside {OP_ADD, OP_SUB, OP_AND};
    assign SC     = sc_q;

    // The immediate reaches the datapath through IROut directly; only Z is consulted here.
    assign unused_inputs = ^{IROut[5:0], ALUOutFlag[2:0]};

    function automatic logic [3:0] onehot(input logic [1:0] idx);
        return 4'b0001 << idx;
    endfunction

    always_comb begin
        case (opcode)
            OP_ADD:  alu_code = ALU_ADD;
            OP_SUB:  alu_code = ALU_SUB;
            default: alu_code = ALU_AND;
        endcase
    end

    always_ff @(posedge Clock) begin
        // NOTE: state registers use non-blocking assignment so every flop samples pre-edge values.
        if (!Reset) begin
            sc_q <= T0;
        end else begin
            sc_q <= sc_d;
        end
    end

    always_comb begin
        // NOTE: every output gets the idle value first, so no path through the case infers a latch.
        RF_OutASel  = 2'b00;
        RF_OutBSel  = 2'b00;
        RF_FunSel   = FUN_CLEAR;
        RF_RegSel   = 4'b0000;
        ALU_FunSel  = ALU_PASS;
        ARF_OutCSel = 2'b00;
        ARF_OutDSel = OUTD_PC;
        ARF_FunSel  = FUN_CLEAR;
        ARF_RegSel  = 3'b000;
        IR_LH       = 1'b0;
        IR_Enable   = 1'b0;
        IR_Funsel   = FUN_CLEAR;
        Mem_WR      = 1'b0;
        Mem_CS      = 1'b1;
        MuxASel     = MUX_ALU;
        MuxBSel     = MUX_ALU;
        MuxCSel     = 1'b0;
        sc_d        = T0;

        if (!Reset) begin
            // Held reset clears every RF and ARF register, which also zeroes PC.
            RF_RegSel  = 4'hF;
            RF_FunSel  = FUN_CLEAR;
            ARF_RegSel = ARF_SEL_ALL;
            ARF_FunSel = FUN_CLEAR;
        end else begin
            case (sc_q)
                T0, T1: begin
                    ARF_OutDSel = OUTD_PC;
                    Mem_CS      = 1'b0;
                    IR_Enable   = 1'b1;
                    IR_Funsel   = FUN_LOAD;
                    IR_LH       = (sc_q == T1);
                    ARF_RegSel  = ARF_SEL_PC;
                    ARF_FunSel  = FUN_INC;
                    sc_d        = (sc_q == T0) ? T1 : T2;
                end
                T2: begin
                    case (opcode)
                        OP_LDI: begin
                            MuxASel   = MUX_IMM;
                            RF_FunSel = FUN_LOAD;
                            RF_RegSel = onehot(rd);
                        end
                        OP_LDM: begin
                            ARF_OutDSel = OUTD_AR;
                            Mem_CS      = 1'b0;
                            MuxASel     = MUX_MEM;
                            RF_FunSel   = FUN_LOAD;
                            RF_RegSel   = onehot(rd);
                        end
                        OP_ST: begin
                            RF_OutASel  = rd;
                            MuxCSel     = 1'b0;
                            ALU_FunSel  = ALU_PASS;
                            ARF_OutDSel = OUTD_AR;
                            Mem_CS      = 1'b0;
                            Mem_WR      = 1'b1;
                        end
                        OP_LDAR: begin
                            MuxBSel    = MUX_IMM;
                            ARF_FunSel = FUN_LOAD;
                            ARF_RegSel = ARF_SEL_AR;
                        end
                        OP_ADD, OP_SUB, OP_AND: begin
                            RF_OutASel = rs1;
                            RF_OutBSel = rs2;
                            MuxCSel    = 1'b0;
                            ALU_FunSel = alu_code;
                            sc_d       = T3;
                        end
                        OP_INC: begin
                            RF_FunSel = FUN_INC;
                            RF_RegSel = onehot(rd);
                        end
                        OP_BRA: begin
                            MuxBSel    = MUX_IMM;
                            ARF_FunSel = FUN_LOAD;
                            ARF_RegSel = ARF_SEL_PC;
                        end
                        OP_BEQ: begin
                            if (ALUOutFlag[3]) begin
                                MuxBSel    = MUX_IMM;
                                ARF_FunSel = FUN_LOAD;
                                ARF_RegSel = ARF_SEL_PC;
                            end
                        end
                        default: begin
                        end
                    endcase
                end
                T3: begin
                    // Only ALU ops legitimately reach T3; anything else falls back to idle.
                    if (alu_op) begin
                        RF_OutASel = rs1;
                        RF_OutBSel = rs2;
                        MuxCSel    = 1'b0;
                        ALU_FunSel = alu_code;
                        MuxASel    = MUX_ALU;
                        RF_FunSel  = FUN_LOAD;
                        RF_RegSel  = onehot(rd);
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_control_sequencer.sv
// Closed-loop bench: a behavioural alu_system executes the sequencer's control words,
// and its architectural state is compared with an instruction-level reference model.
module tb_control_sequencer;

    logic        Clock = 1'b0;
    logic        Reset;
    logic [3:0]  ALUOutFlag;
    logic [1:0]  RF_OutASel, RF_OutBSel, RF_FunSel;
    logic [3:0]  RF_RegSel, ALU_FunSel;
    logic [1:0]  ARF_OutCSel, ARF_OutDSel, ARF_FunSel;
    logic [2:0]  ARF_RegSel;
    logic        IR_LH, IR_Enable;
    logic [1:0]  IR_Funsel;
    logic        Mem_WR, Mem_CS;
    logic [1:0]  MuxASel, MuxBSel;
    logic        MuxCSel;
    logic [1:0]  SC;

    always #5 Clock = ~Clock;

    // Datapath stand-in
    logic [7:0]  rf [4];
    logic [7:0]  pc_q, ar_q, sp_q;
    logic [15:0] ir_q;
    logic [7:0]  mem [256];
    logic        clear_en, poke_en;
    logic [7:0]  poke_addr;
    logic [15:0] poke_word;
    logic [7:0]  arf_c, arf_d, rf_a, rf_b, alu_a, alu_out, mem_out, mux_a, mux_b;

    control_sequencer dut (
        .Clock      (Clock),
        .Reset      (Reset),
        .IROut      (ir_q),
        .ALUOutFlag (ALUOutFlag),
        .RF_OutASel (RF_OutASel),
        .RF_OutBSel (RF_OutBSel),
        .RF_FunSel  (RF_FunSel),
        .RF_RegSel  (RF_RegSel),
        .ALU_FunSel (ALU_FunSel),
        .ARF_OutCSel(ARF_OutCSel),
        .ARF_OutDSel(ARF_OutDSel),
        .ARF_FunSel (ARF_FunSel),
        .ARF_RegSel (ARF_RegSel),
        .IR_LH      (IR_LH),
        .IR_Enable  (IR_Enable),
        .IR_Funsel  (IR_Funsel),
        .Mem_WR     (Mem_WR),
        .Mem_CS     (Mem_CS),
        .MuxASel    (MuxASel),
        .MuxBSel    (MuxBSel),
        .MuxCSel    (MuxCSel),
        .SC         (SC)
    );

    function automatic logic [7:0] arf_pick(input logic [1:0] sel, input logic [7:0] pc,
                                            input logic [7:0] ar, input logic [7:0] sp);
        case (sel)
            2'b00:   return pc;
            2'b01:   return ar;
            default: return sp;
        endcase
    endfunction

    function automatic logic [7:0] fun_apply(input logic [1:0] fs, input logic [7:0] cur,
                                             input logic [7:0] din);
        case (fs)
            2'b00:   return 8'h00;
            2'b01:   return din;
            2'b10:   return cur - 8'd1;
            default: return cur + 8'd1;
        endcase
    endfunction

    assign arf_c   = arf_pick(ARF_OutCSel, pc_q, ar_q, sp_q);
    assign arf_d   = arf_pick(ARF_OutDSel, pc_q, ar_q, sp_q);
    assign rf_a    = rf[RF_OutASel];
    assign rf_b    = rf[RF_OutBSel];
    assign alu_a   = MuxCSel ? arf_c : rf_a;
    assign mem_out = mem[arf_d];

    always_comb begin
        case (ALU_FunSel)
            4'b0000: alu_out = alu_a;
            4'b0100: alu_out = alu_a + rf_b;
            4'b0101: alu_out = alu_a - rf_b;
            4'b0111: alu_out = alu_a & rf_b;
            default: alu_out = 8'h00;
        endcase
        case (MuxASel)
            2'b00:   mux_a = alu_out;
            2'b01:   mux_a = mem_out;
            2'b10:   mux_a = ir_q[7:0];
            default: mux_a = arf_c;
        endcase
        case (MuxBSel)
            2'b00:   mux_b = alu_out;
            2'b01:   mux_b = mem_out;
            2'b10:   mux_b = ir_q[7:0];
            default: mux_b = arf_c;
        endcase
    end

    always_ff @(posedge Clock) begin
        for (int i = 0; i < 4; i++) begin
            if (RF_RegSel[i]) rf[i] <= fun_apply(RF_FunSel, rf[i], mux_a);
        end
        if (ARF_RegSel[2]) pc_q <= fun_apply(ARF_FunSel, pc_q, mux_b);
        if (ARF_RegSel[1]) ar_q <= fun_apply(ARF_FunSel, ar_q, mux_b);
        if (ARF_RegSel[0]) sp_q <= fun_apply(ARF_FunSel, sp_q, mux_b);
        if (IR_Enable) begin
            if (IR_LH) ir_q[15:8] <= fun_apply(IR_Funsel, ir_q[15:8], mem_out);
            else       ir_q[7:0]  <= fun_apply(IR_Funsel, ir_q[7:0], mem_out);
        end
        if (!Mem_CS && Mem_WR) mem[arf_d] <= alu_out;
        if (clear_en) begin
            for (int i = 0; i < 256; i++) mem[i] <= 8'h00;
            ir_q <= 16'h0000;
        end
        // Program bytes are planted last so they win over a same-edge store.
        if (poke_en) begin
            mem[poke_addr]        <= poke_word[7:0];
            mem[poke_addr + 8'd1] <= poke_word[15:8];
        end
    end

    // Instruction-level reference state
    logic [7:0] m_rf [4];
    logic [7:0] m_pc, m_ar, m_sp;
    logic [7:0] m_mem [256];
    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
        n_tests++;
        assert (got === exp) else begin
            n_fail++;
            $error("FAIL %s: got %h, expected %h", tag, got, exp);
        end
    endtask

    task automatic reset_model();
        for (int i = 0; i < 4; i++) m_rf[i] = 8'h00;
        m_pc = 8'h00;
        m_ar = 8'h00;
        m_sp = 8'h00;
    endtask

    task automatic isa_exec(input logic [15:0] w, input logic z);
        logic [3:0] op;
        logic [1:0] rd, rs1, rs2;
        logic [7:0] imm;
        op  = w[15:12];
        rd  = w[11:10];
        rs1 = w[9:8];
        rs2 = w[7:6];
        imm = w[7:0];
        m_pc = m_pc + 8'd2;
        case (op)
            4'h0: m_rf[rd] = imm;
            4'h1: m_rf[rd] = m_mem[m_ar];
            4'h2: m_mem[m_ar] = m_rf[rd];
            4'h3: m_ar = imm;
            4'h4: m_rf[rd] = m_rf[rs1] + m_rf[rs2];
            4'h5: m_rf[rd] = m_rf[rs1] - m_rf[rs2];
            4'h6: m_rf[rd] = m_rf[rs1] & m_rf[rs2];
            4'h7: m_rf[rd] = m_rf[rd] + 8'd1;
            4'h8: m_pc = imm;
            4'h9: if (z) m_pc = imm;
            default: ;
        endcase
    endtask

    task automatic check_arch(input string tag);
        for (int i = 0; i < 4; i++) check($sformatf("%s R%0d", tag, i + 1), 16'(rf[i]), 16'(m_rf[i]));
        check({tag, " PC"}, 16'(pc_q), 16'(m_pc));
        check({tag, " AR"}, 16'(ar_q), 16'(m_ar));
        check({tag, " SP"}, 16'(sp_q), 16'(m_sp));
    endtask

    // Entered at the negedge of the cycle before T0; returns at the negedge of T2.
    task automatic start_instr(input logic [15:0] w, input logic z, input string tag);
        poke_en   = 1'b1;
        poke_addr = m_pc;
        poke_word = w;
        m_mem[m_pc]        = w[7:0];
        m_mem[m_pc + 8'd1] = w[15:8];
        @(posedge Clock);
        #1;
        poke_en    = 1'b0;
        Reset      = 1'b1;
        ALUOutFlag = {z, 3'($urandom)};
        @(negedge Clock);
        check_arch(tag);
        check({tag, " T0 sc"}, 16'(SC), 16'd0);
        check({tag, " T0 fetch"},
              16'({IR_Enable, IR_LH, IR_Funsel, Mem_CS, Mem_WR, ARF_RegSel, ARF_FunSel, ARF_OutDSel}),
              16'({1'b1, 1'b0, 2'b01, 1'b0, 1'b0, 3'b100, 2'b11, 2'b00}));
        @(negedge Clock);
        check({tag, " T1 sc"}, 16'(SC), 16'd1);
        check({tag, " T1 fetch"},
              16'({IR_Enable, IR_LH, IR_Funsel, Mem_CS, Mem_WR, ARF_RegSel, ARF_FunSel, ARF_OutDSel}),
              16'({1'b1, 1'b1, 2'b01, 1'b0, 1'b0, 3'b100, 2'b11, 2'b00}));
        @(negedge Clock);
        check({tag, " T2 sc"}, 16'(SC), 16'd2);
    endtask

    task automatic step_t3(input string tag);
        @(negedge Clock);
        check({tag, " T3 sc"}, 16'(SC), 16'd3);
    endtask

    task automatic run_instr(input logic [15:0] w, input logic z, input string tag);
        start_instr(w, z, tag);
        if (w[15:12] inside {4'h4, 4'h5, 4'h6}) step_t3(tag);
        isa_exec(w, z);
    endtask

    initial begin
        Reset      = 1'b0;
        ALUOutFlag = 4'h0;
        poke_en    = 1'b0;
        poke_addr  = 8'h00;
        poke_word  = 16'h0000;
        clear_en   = 1'b1;
        for (int i = 0; i < 256; i++) m_mem[i] = 8'h00;
        reset_model();

        @(posedge Clock);
        #1;
        clear_en = 1'b0;
        @(negedge Clock);
        check("reset sc", 16'(SC), 16'd0);
        check("reset word",
              16'({RF_RegSel, RF_FunSel, ARF_RegSel, ARF_FunSel, Mem_CS, IR_Enable}),
              16'({4'hF, 2'b00, 3'b111, 2'b00, 1'b1, 1'b0}));

        // LDI R2, 0x2A
        start_instr(16'h042A, 1'b0, "ldi");
        check("ldi T2 word", 16'({MuxASel, RF_RegSel, RF_FunSel}), 16'({2'b10, 4'b0010, 2'b01}));
        isa_exec(16'h042A, 1'b0);

        // ADD R1 <- R2 + R2
        start_instr(16'h4140, 1'b0, "add");
        check("add T2 word", 16'({RF_OutASel, RF_OutBSel, ALU_FunSel, RF_RegSel, MuxCSel}),
              16'({2'b01, 2'b01, 4'b0100, 4'b0000, 1'b0}));
        step_t3("add");
        check("add T3 word", 16'({RF_RegSel, MuxASel, RF_FunSel, ALU_FunSel}),
              16'({4'b0001, 2'b00, 2'b01, 4'b0100}));
        isa_exec(16'h4140, 1'b0);

        // BEQ 0x10, not taken then taken
        start_instr(16'h9010, 1'b0, "beq z0");
        check("add R1 value", 16'(rf[0]), 16'h0054);
        check("ldi R2 value", 16'(rf[1]), 16'h002A);
        check("beq z0 T2 word", 16'({ARF_RegSel, MuxBSel, Mem_CS}), 16'({3'b000, 2'b00, 1'b1}));
        isa_exec(16'h9010, 1'b0);
        start_instr(16'h9010, 1'b1, "beq z1");
        check("beq z1 T2 word", 16'({ARF_RegSel, MuxBSel, ARF_FunSel}), 16'({3'b100, 2'b10, 2'b01}));
        isa_exec(16'h9010, 1'b1);

        // LDI R4, 0x5A at the branch target; LDAR 0x30; ST R4
        start_instr(16'h0C5A, 1'b0, "ldi r4");
        check("branch target pc", 16'(pc_q), 16'h0012);
        isa_exec(16'h0C5A, 1'b0);
        start_instr(16'h3030, 1'b0, "ldar");
        check("ldar T2 word", 16'({MuxBSel, ARF_FunSel, ARF_RegSel}), 16'({2'b10, 2'b01, 3'b010}));
        isa_exec(16'h3030, 1'b0);
        start_instr(16'h2C00, 1'b0, "st");
        check("st AR", 16'(ar_q), 16'h0030);
        check("st T2 word", 16'({Mem_CS, Mem_WR, ARF_OutDSel, RF_OutASel, MuxCSel, ALU_FunSel}),
              16'({1'b0, 1'b1, 2'b01, 2'b11, 1'b0, 4'b0000}));
        isa_exec(16'h2C00, 1'b0);

        // Illegal opcode idles
        start_instr(16'hF123, 1'b1, "illegal");
        check("st stored byte", 16'(mem[8'h30]), 16'h005A);
        check("illegal T2 word", 16'({RF_RegSel, ARF_RegSel, IR_Enable, Mem_CS, Mem_WR}),
              16'({4'b0000, 3'b000, 1'b0, 1'b1, 1'b0}));
        isa_exec(16'hF123, 1'b1);

        // Reset asserted at T2 of ADD R3 <- R2 + R4
        start_instr(16'h49C0, 1'b0, "abort");
        Reset = 1'b0;
        #1;
        check("abort reset word",
              16'({RF_RegSel, RF_FunSel, ARF_RegSel, ARF_FunSel, Mem_CS, IR_Enable}),
              16'({4'hF, 2'b00, 3'b111, 2'b00, 1'b1, 1'b0}));
        reset_model();

        for (int k = 0; k < 300; k++) begin
            run_instr(16'($urandom), 1'($urandom), $sformatf("rnd%0d", k));
        end

        @(negedge Clock);
        check_arch("final");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/control_sequencer.md
Name: control_sequencer

Overview:
- Hardwired control unit that drives every control input of alu_system.
- Each instruction is a 16-bit word fetched as two bytes into IR (low byte first). The block decodes IROut and issues per-cycle control words through a 2-bit sequence counter (T0..T3).
- Sits directly upstream of alu_system. It consumes IROut and ALUOutFlag and produces all register, mux and memory select/enable signals.

Parameters:
- ALU_PASS, 4'b0000, ALU_FunSel code for "pass A" used by ST.
- ALU_ADD, 4'b0100, ALU_FunSel code for ADD.
- ALU_SUB, 4'b0101, ALU_FunSel code for SUB.
- ALU_AND, 4'b0111, ALU_FunSel code for AND.

Ports:
- Clock  in  1  system clock; all state updates on rising edge.
- Reset  in  1  synchronous, active-low.
- IROut  in  16  instruction register contents. [15:12] opcode, [11:10] Rd, [9:8] Rs1, [7:6] Rs2, [7:0] imm/addr.
- ALUOutFlag  in  4  {Z,C,N,O}, Z = bit 3.
- RF_OutASel, RF_OutBSel  out  2 each.
- RF_FunSel  out  2.
- RF_RegSel  out  4.
- ALU_FunSel  out  4.
- ARF_OutCSel, ARF_OutDSel  out  2 each.
- ARF_FunSel  out  2.
- ARF_RegSel  out  3.
- IR_LH, IR_Enable  out  1 each.
- IR_Funsel  out  2.
- Mem_WR, Mem_CS  out  1 each.
- MuxASel, MuxBSel  out  2 each.
- MuxCSel  out  1.
- SC  out  2  current sequence step, for debug/verification.

Behaviour:
- Encodings:
  - FunSel (RF/ARF/IR): 00 clear, 01 load, 10 decrement, 11 increment.
  - RF_RegSel: one-hot active-high, bit i enables R(i+1).
  - ARF_RegSel: {PC,AR,SP}.
  - ARF_OutDSel: 00 PC, 01 AR, 10 SP.
  - MuxA (RF input) / MuxB (ARF input): 00 ALUOut, 01 MemoryOut, 10 IROut[7:0], 11 ARF_COut.
  - MuxCSel: 0 = RF AOut to ALU A.
  - Mem_CS: active-low. Mem_WR: 1 = write.
  - IR_LH: 0 loads IR[7:0], 1 loads IR[15:8].
- Idle word (every output not listed for a step):
  - RF_RegSel = 0, ARF_RegSel = 0, IR_Enable = 0.
  - Mem_CS = 1, Mem_WR = 0.
  - All selects = 0; ALU_FunSel = ALU_PASS.
- Outputs are combinational from SC and IROut. SC is the only state register.
- Reset = 0 at a rising edge:
  - SC <= 0.
  - While Reset = 0, outputs drive RF_RegSel = 4'hF, RF_FunSel = 00, ARF_RegSel = 3'b111, ARF_FunSel = 00. This clears all registers, so PC = 0.
  - Mem_CS = 1, IR_Enable = 0.
  - Reset mid-instruction aborts it; the first fetch starts at T0 after release.
- T0 (fetch low):
  - ARF_OutDSel = 00, Mem_CS = 0, Mem_WR = 0.
  - IR_Enable = 1, IR_Funsel = 01, IR_LH = 0.
  - ARF_RegSel = 100, ARF_FunSel = 11 (PC++).
  - SC -> 1.
- T1 (fetch high): same as T0 with IR_LH = 1; SC -> 2.
- T2 (execute, by opcode):
  - 0 LDI: MuxASel = 10, RF_FunSel = 01, RF_RegSel = onehot(Rd).
  - 1 LDM: ARF_OutDSel = 01, Mem_CS = 0, MuxASel = 01, RF load onehot(Rd).
  - 2 ST: RF_OutASel = Rd, MuxCSel = 0, ALU_FunSel = ALU_PASS, ARF_OutDSel = 01, Mem_CS = 0, Mem_WR = 1.
  - 3 LDAR: MuxBSel = 10, ARF_FunSel = 01, ARF_RegSel = 010.
  - 4/5/6 ADD/SUB/AND:
    - RF_OutASel = Rs1, RF_OutBSel = Rs2, MuxCSel = 0, ALU_FunSel = ADD/SUB/AND.
    - No register write. SC -> 3.
  - 7 INC: RF_FunSel = 11, RF_RegSel = onehot(Rd).
  - 8 BRA: MuxBSel = 10, ARF_FunSel = 01, ARF_RegSel = 100.
  - 9 BEQ: as BRA if ALUOutFlag[3] = 1 in this cycle, else idle word.
  - A-F: illegal; idle word, no state change besides SC.
  - All opcodes except 4/5/6: SC -> 0.
- T3 (opcodes 4/5/6 only):
  - Hold T2 selects and ALU_FunSel.
  - MuxASel = 00, RF_FunSel = 01, RF_RegSel = onehot(Rd).
  - SC -> 0.
- Latency: 3 cycles per instruction, 4 for ADD/SUB/AND. No wait states.
- SC never reaches 3 for other opcodes; an SC = 3 with another opcode forces the idle word and SC -> 0.
- PC wraps 0xFF -> 0x00 naturally in ARF. The sequencer does not check for it.

Test Plan:
- Reset = 0 for 2 cycles:
  - Required: SC = 0; RF_RegSel = F, RF_FunSel = 00, ARF_RegSel = 7, ARF_FunSel = 00.
  - After release, next cycle is T0 with IR_LH = 0, ARF_OutDSel = 00, Mem_CS = 0, ARF_FunSel = 11.
- Memory bytes {0x2A, 0x04} (IR = 0x042A, LDI R2, 0x2A):
  - Required: T2 drives MuxASel = 10, RF_RegSel = 0010, RF_FunSel = 01; R2 = 0x2A; SC returns to 0 after 3 cycles.
- IR = 0x4140 (ADD R1 <- R2 + R2):
  - T2: RF_OutASel = 01, RF_OutBSel = 01, ALU_FunSel = 0100, RF_RegSel = 0.
  - T3: RF_RegSel = 0001, MuxASel = 00.
  - With R2 = 0x2A, R1 = 0x54.
- IR = 0x9010 (BEQ 0x10):
  - Z = 0: no ARF write; PC = old PC + 2.
  - Z = 1: ARF_RegSel = 100, MuxBSel = 10; PC = 0x10.
- IR = 0x2C00 (ST R4) with AR = 0x30:
  - T2: Mem_CS = 0, Mem_WR = 1, ARF_OutDSel = 01, RF_OutASel = 11; M[0x30] = R4.
- Opcode 0xF, and Reset = 0 asserted at T2 of an ADD:
  - Opcode 0xF: idle T2, no writes.
  - Reset during ADD: aborted, no RF write; SC = 0 after release.
